// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the intersection light-bus monitor.
//   - light codes {R,Y,G} one-hot
//   - decoded phase encoding (0..4)
//   - fault codes (0..5)
//   - sequence-tracker state type and successor helper
package traffic_pkg;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [2:0] PH_ALL_RED = 3'd0;
    localparam logic [2:0] PH_HW_G    = 3'd1;
    localparam logic [2:0] PH_HW_Y    = 3'd2;
    localparam logic [2:0] PH_FARM_G  = 3'd3;
    localparam logic [2:0] PH_FARM_Y  = 3'd4;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ENCODING = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;
    localparam logic [2:0] FC_STUCK    = 3'd5;

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_HWG  = 3'd1,
        ST_HWY  = 3'd2,
        ST_AR1  = 3'd3,
        ST_FG   = 3'd4,
        ST_FY   = 3'd5,
        ST_AR2  = 3'd6
    } seq_state_t;

    // Phase that must follow the phase tracked by a locked state.
    function automatic logic [2:0] expected_phase(input seq_state_t s);
        logic [2:0] p;
        case (s)
            ST_HWG:  p = PH_HW_Y;
            ST_HWY:  p = PH_ALL_RED;
            ST_AR1:  p = PH_FARM_G;
            ST_FG:   p = PH_FARM_Y;
            ST_FY:   p = PH_ALL_RED;
            ST_AR2:  p = PH_HW_G;
            default: p = PH_HW_G;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if: light-bus observation interface.
//   master: drives light_highway, light_farm, fault_clear; observes results.
//   slave : the monitor; consumes the lights and drives fault/phase reports.
//   cycle_count exists only when TRAFFIC_MONITOR_STATS_EN is defined.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       light_highway;
    logic [2:0]       light_farm;
    logic             fault_clear;
    logic             fault;
    logic [2:0]       fault_code;
    logic             in_sync;
    logic [2:0]       cur_phase;
    logic             phase_done;
    logic [2:0]       done_phase;
    logic [CNT_W-1:0] phase_len;
`ifdef TRAFFIC_MONITOR_STATS_EN
    logic [15:0]      cycle_count;
`endif

    modport master (
        output light_highway, light_farm, fault_clear,
        input  fault, fault_code, in_sync, cur_phase, phase_done, done_phase, phase_len
`ifdef TRAFFIC_MONITOR_STATS_EN
        , input cycle_count
`endif
    );

    modport slave (
        input  light_highway, light_farm, fault_clear,
        output fault, fault_code, in_sync, cur_phase, phase_done, done_phase, phase_len
`ifdef TRAFFIC_MONITOR_STATS_EN
        , output cycle_count
`endif
    );

endinterface

// File: rtl/traffic_light_monitor_decode.sv
// light_decode: classifies one road's 3-bit {R,Y,G} light code.
//   code    in  3  light code
//   is_red/is_yel/is_grn  out  legal single-lamp codes
//   illegal out  code is not one of 100/010/001
module light_decode
    import traffic_pkg::*;
(
    input  logic [2:0] code,
    output logic       is_red,
    output logic       is_yel,
    output logic       is_grn,
    output logic       illegal
);

    // One-hot classification; anything else is an encoding error.
    always_comb begin
        is_red  = 1'b0;
        is_yel  = 1'b0;
        is_grn  = 1'b0;
        illegal = 1'b0;
        case (code)
            RED:     is_red  = 1'b1;
            YEL:     is_yel  = 1'b1;
            GRN:     is_grn  = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive safety checker for the intersection light bus.
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-high reset
//   bus    slave modport of traffic_light_monitor_if (lights, fault_clear in;
//          fault, fault_code, in_sync, cur_phase, phase_done, done_phase,
//          phase_len out)
// Optional build macro TRAFFIC_MONITOR_STATS_EN adds bus.cycle_count, the
// number of completed locked AR2->HWG transitions.
// Lights are registered once; every check runs on the registered pair and
// every output is registered, giving two cycles from input to output.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int HW_GREEN_MIN   = 25,
    parameter int FARM_GREEN_MIN = 15,
    parameter int YELLOW_LEN     = 5,
    parameter int YELLOW_TOL     = 2,
    parameter int ALLRED_MIN     = 2,
    parameter int WATCHDOG       = 64
)
(
    input logic                    clk,
    input logic                    reset,
    traffic_light_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [CNT_W-1:0] HW_MIN_C  = CNT_W'(HW_GREEN_MIN);
    localparam logic [CNT_W-1:0] FG_MIN_C  = CNT_W'(FARM_GREEN_MIN);
    localparam logic [CNT_W-1:0] Y_MIN_C   = CNT_W'(YELLOW_LEN);
    localparam logic [CNT_W-1:0] Y_MAX_C   = CNT_W'(YELLOW_LEN + YELLOW_TOL);
    localparam logic [CNT_W-1:0] AR_MIN_C  = CNT_W'(ALLRED_MIN);
    localparam logic [CNT_W-1:0] WD_C      = CNT_W'(WATCHDOG);

    logic [2:0]       hw_r, farm_r, prev_hw_r, prev_farm_r;
    logic             hw_red_s, hw_yel_s, hw_grn_s, hw_ill_s;
    logic             farm_red_s, farm_yel_s, farm_grn_s, farm_ill_s;
    logic             conflict_s, illegal_s, change_s, short_s;
    logic [2:0]       phase_s, fault_ev_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    seq_state_t       state_r, state_nxt_s;
    logic             fault_r, in_sync_r, phase_done_r;
    logic [2:0]       fault_code_r, cur_phase_r, done_phase_r;
    logic [CNT_W-1:0] phase_len_r;

    light_decode u_dec_hw (
        .code    (hw_r),
        .is_red  (hw_red_s),
        .is_yel  (hw_yel_s),
        .is_grn  (hw_grn_s),
        .illegal (hw_ill_s)
    );

    light_decode u_dec_farm (
        .code    (farm_r),
        .is_red  (farm_red_s),
        .is_yel  (farm_yel_s),
        .is_grn  (farm_grn_s),
        .illegal (farm_ill_s)
    );

    // Single input register stage; resets to an all-red pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            hw_r   <= RED;
            farm_r <= RED;
        end else begin
            hw_r   <= bus.light_highway;
            farm_r <= bus.light_farm;
        end
    end

    // Pair classification and phase decode; phase_s is meaningful only when
    // the pair is legal (exactly one road may be non-red).
    always_comb begin
        conflict_s = !hw_red_s && !farm_red_s;
        illegal_s  = hw_ill_s || farm_ill_s;
        change_s   = (hw_r != prev_hw_r) || (farm_r != prev_farm_r);
        if (hw_grn_s) begin
            phase_s = PH_HW_G;
        end else if (hw_yel_s) begin
            phase_s = PH_HW_Y;
        end else if (farm_grn_s) begin
            phase_s = PH_FARM_G;
        end else if (farm_yel_s) begin
            phase_s = PH_FARM_Y;
        end else begin
            phase_s = PH_ALL_RED;
        end
    end

    // Saturating duration counter, reloaded to 1 on the first cycle of a phase.
    always_comb begin
        if (change_s) begin
            cnt_nxt_s = CNT_ONE_C;
        end else if (cnt_r == CNT_MAX_C) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE_C;
        end
    end

    // Length rule for the phase that the locked tracker is leaving.
    always_comb begin
        case (state_r)
            ST_HWG:         short_s = (cnt_r < HW_MIN_C);
            ST_FG:          short_s = (cnt_r < FG_MIN_C);
            ST_HWY, ST_FY:  short_s = (cnt_r < Y_MIN_C) || (cnt_r > Y_MAX_C);
            ST_AR1, ST_AR2: short_s = (cnt_r < AR_MIN_C);
            default:        short_s = 1'b0;
        endcase
    end

    // Fault event this cycle; the chain order makes the lowest code win.
    always_comb begin
        if (conflict_s) begin
            fault_ev_s = FC_CONFLICT;
        end else if (illegal_s) begin
            fault_ev_s = FC_ENCODING;
        end else if (change_s && (state_r != ST_SYNC) && (phase_s != expected_phase(state_r))) begin
            fault_ev_s = FC_SEQUENCE;
        end else if (change_s && (state_r != ST_SYNC) && short_s) begin
            fault_ev_s = FC_SHORT;
        end else if (cnt_nxt_s >= WD_C) begin
            fault_ev_s = FC_STUCK;
        end else begin
            fault_ev_s = FC_NONE;
        end
    end

    // Sequence tracker next state; any fault drops back to SYNC.
    always_comb begin
        state_nxt_s = state_r;
        if (fault_ev_s != FC_NONE) begin
            state_nxt_s = ST_SYNC;
        end else if (change_s) begin
            case (state_r)
                ST_SYNC: state_nxt_s = (phase_s == PH_HW_G) ? ST_HWG : ST_SYNC;
                ST_HWG:  state_nxt_s = ST_HWY;
                ST_HWY:  state_nxt_s = ST_AR1;
                ST_AR1:  state_nxt_s = ST_FG;
                ST_FG:   state_nxt_s = ST_FY;
                ST_FY:   state_nxt_s = ST_AR2;
                ST_AR2:  state_nxt_s = ST_HWG;
                default: state_nxt_s = ST_SYNC;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Tracker state, duration counter and previous-pair history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_SYNC;
            cnt_r       <= '0;
            prev_hw_r   <= RED;
            prev_farm_r <= RED;
            in_sync_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            prev_hw_r   <= hw_r;
            prev_farm_r <= farm_r;
            in_sync_r   <= (state_nxt_s != ST_SYNC);
        end
    end

    // Sticky fault: first code latches; a fault coinciding with clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
        end else if ((fault_ev_s != FC_NONE) && (!fault_r || bus.fault_clear)) begin
            fault_r      <= 1'b1;
            fault_code_r <= fault_ev_s;
        end else if (bus.fault_clear) begin
            fault_r      <= 1'b0;
            fault_code_r <= FC_NONE;
        end else begin
            fault_r      <= fault_r;
            fault_code_r <= fault_code_r;
        end
    end

    // Phase reporting; cur_phase only follows legal pairs, so an illegal
    // interval is reported under the last legal phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_phase_r  <= PH_ALL_RED;
            phase_done_r <= 1'b0;
            done_phase_r <= PH_ALL_RED;
            phase_len_r  <= '0;
        end else begin
            cur_phase_r  <= (conflict_s || illegal_s) ? cur_phase_r : phase_s;
            phase_done_r <= change_s;
            done_phase_r <= change_s ? cur_phase_r : done_phase_r;
            phase_len_r  <= change_s ? cnt_r : phase_len_r;
        end
    end

    assign bus.fault      = fault_r;
    assign bus.fault_code = fault_code_r;
    assign bus.in_sync    = in_sync_r;
    assign bus.cur_phase  = cur_phase_r;
    assign bus.phase_done = phase_done_r;
    assign bus.done_phase = done_phase_r;
    assign bus.phase_len  = phase_len_r;

`ifdef TRAFFIC_MONITOR_STATS_EN
    logic [15:0] cycle_count_r;
    logic        wrap_s;

    assign wrap_s = change_s && (state_r == ST_AR2) && (fault_ev_s == FC_NONE);

    // Completed-cycle counter; wraps naturally and freezes while faulted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count_r <= 16'd0;
        end else if (wrap_s && !fault_r) begin
            cycle_count_r <= cycle_count_r + 16'd1;
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign bus.cycle_count = cycle_count_r;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor. Phase reports are scored against
// a queue of expected {phase, length} entries pushed as stimulus is applied.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [2:0]       ph;
        logic [CNT_W-1:0] len;
    } rep_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    rep_t exp_q[$];

    traffic_light_monitor_if #(.CNT_W(CNT_W)) tbif ();

    traffic_light_monitor dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic expect_rep(input logic [2:0] ph, input int len);
        rep_t r;
        r.ph  = ph;
        r.len = CNT_W'(len);
        exp_q.push_back(r);
    endtask

    // Hold a light pair for n rising edges; returns 1 time unit after the last.
    task automatic drive(input logic [2:0] hw, input logic [2:0] fm, input int n);
        tbif.light_highway = hw;
        tbif.light_farm    = fm;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        tbif.fault_clear = 1'b1;
        @(posedge clk);
        #1;
        tbif.fault_clear = 1'b0;
    endtask

    task automatic check_fault(input string tag, input logic f, input logic [2:0] code);
        check({tag, "_fault"}, 16'(tbif.fault), 16'(f));
        check({tag, "_code"}, 16'(tbif.fault_code), 16'(code));
    endtask

    task automatic check_reset_vals(input string tag);
        check_fault(tag, 1'b0, FC_NONE);
        check({tag, "_in_sync"}, 16'(tbif.in_sync), 16'd0);
        check({tag, "_cur_phase"}, 16'(tbif.cur_phase), 16'(PH_ALL_RED));
        check({tag, "_phase_done"}, 16'(tbif.phase_done), 16'd0);
        check({tag, "_done_phase"}, 16'(tbif.done_phase), 16'd0);
        check({tag, "_phase_len"}, 16'(tbif.phase_len), 16'd0);
    endtask

    // Scoreboard: every phase_done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && tbif.phase_done) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_report observed=%0d/%0d expected=none",
                       tbif.done_phase, tbif.phase_len);
            end
            if (exp_q.size() > 0) begin
                rep_t r;
                r = exp_q.pop_front();
                check("done_phase", 16'(tbif.done_phase), 16'(r.ph));
                check("phase_len", 16'(tbif.phase_len), 16'(r.len));
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        tbif.light_highway = RED;
        tbif.light_farm    = RED;
        tbif.fault_clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");

        // The input register resets to all-red, which counts as one extra
        // all-red cycle before the first driven sample.
        reset = 1'b0;
        expect_rep(PH_ALL_RED, 4);
        drive(RED, RED, 3);

        // Nominal cycles.
        for (int i = 0; i < 3; i++) begin
            expect_rep(PH_HW_G, 26);
            drive(GRN, RED, 1);
            check("in_sync_hwg_e1", 16'(tbif.in_sync), 16'(i != 0));
            drive(GRN, RED, 1);
            check("in_sync_hwg_e2", 16'(tbif.in_sync), 16'd1);
            check("cur_phase_hwg", 16'(tbif.cur_phase), 16'(PH_HW_G));
            drive(GRN, RED, 24);
            expect_rep(PH_HW_Y, 6);
            drive(YEL, RED, 6);
            expect_rep(PH_ALL_RED, 3);
            drive(RED, RED, 3);
            expect_rep(PH_FARM_G, 16);
            drive(RED, GRN, 16);
            expect_rep(PH_FARM_Y, 6);
            drive(RED, YEL, 6);
            expect_rep(PH_ALL_RED, 3);
            drive(RED, RED, 3);
            check("nominal_fault", 16'(tbif.fault), 16'd0);
        end
        check("cur_phase_ar", 16'(tbif.cur_phase), 16'(PH_ALL_RED));
`ifdef TRAFFIC_MONITOR_STATS_EN
        check("cycle_count", tbif.cycle_count, 16'd2);
`endif

        // Conflict for one cycle mid highway-green.
        expect_rep(PH_HW_G, 10);
        drive(GRN, RED, 10);
        expect_rep(PH_HW_G, 1);
        drive(GRN, GRN, 1);
        expect_rep(PH_HW_G, 10);
        drive(GRN, RED, 1);
        check_fault("conflict", 1'b1, FC_CONFLICT);
        check("conflict_in_sync", 16'(tbif.in_sync), 16'd0);
        drive(GRN, RED, 3);
        check_fault("conflict_sticky", 1'b1, FC_CONFLICT);
        pulse_clear();
        check_fault("conflict_clr", 1'b0, FC_NONE);
        drive(GRN, RED, 5);

        // Illegal highway encoding; clear collides with the second bad sample.
        expect_rep(PH_HW_G, 2);
        drive(3'b110, RED, 2);
        check_fault("encoding", 1'b1, FC_ENCODING);
        check("encoding_cur_phase", 16'(tbif.cur_phase), 16'(PH_HW_G));
        expect_rep(PH_ALL_RED, 4);
        tbif.fault_clear = 1'b1;
        drive(RED, RED, 1);
        tbif.fault_clear = 1'b0;
        check_fault("enc_clr_collide", 1'b1, FC_ENCODING);
        pulse_clear();
        check_fault("enc_clr", 1'b0, FC_NONE);
        drive(RED, RED, 2);

        // Locked highway green straight to all-red.
        expect_rep(PH_HW_G, 26);
        drive(GRN, RED, 26);
        expect_rep(PH_ALL_RED, 4);
        drive(RED, RED, 2);
        check_fault("sequence", 1'b1, FC_SEQUENCE);
        check("sequence_in_sync", 16'(tbif.in_sync), 16'd0);
        pulse_clear();
        check_fault("seq_clr", 1'b0, FC_NONE);
        drive(RED, RED, 1);

        // Resync, then a 10-cycle farm green.
        expect_rep(PH_HW_G, 26);
        drive(GRN, RED, 26);
        expect_rep(PH_HW_Y, 6);
        drive(YEL, RED, 6);
        expect_rep(PH_ALL_RED, 3);
        drive(RED, RED, 3);
        expect_rep(PH_FARM_G, 10);
        drive(RED, GRN, 10);
        expect_rep(PH_FARM_Y, 6);
        drive(RED, YEL, 2);
        check_fault("short", 1'b1, FC_SHORT);
        drive(RED, YEL, 4);

        // Stuck all-red: watchdog at a count of 64.
        expect_rep(PH_ALL_RED, 70);
        tbif.light_highway = RED;
        tbif.light_farm    = RED;
        pulse_clear();
        check_fault("stuck_clr", 1'b0, FC_NONE);
        drive(RED, RED, 63);
        check_fault("stuck_63", 1'b0, FC_NONE);
        drive(RED, RED, 1);
        check_fault("stuck_64", 1'b1, FC_STUCK);
        drive(RED, RED, 5);

        // Reset in the middle of farm yellow.
        drive(RED, YEL, 5);
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("reset_mid");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_rep(PH_ALL_RED, 4);
        drive(RED, RED, 3);
        drive(GRN, RED, 1);
        check("resume_in_sync_e1", 16'(tbif.in_sync), 16'd0);
        drive(GRN, RED, 1);
        check("resume_in_sync_e2", 16'(tbif.in_sync), 16'd1);
        check("resume_fault", 16'(tbif.fault), 16'd0);
        check("resume_cur_phase", 16'(tbif.cur_phase), 16'(PH_HW_G));
        drive(GRN, RED, 3);
        check("queue_final", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
